// File: rtl/tdc_s3_pkg.sv
// Shared definitions for the tdc_s3 readout slice: word geometry, the
// identifier field, the arbiter state type and small helper functions.
package tdc_s3_pkg;

    localparam int TDC_W  = 32;
    localparam int ID_MSB = 31;
    localparam int ID_LSB = 28;
    localparam int ID_W   = ID_MSB - ID_LSB + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Index width for n items; never below 1 so a 2-channel build still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Overwrite the data-identifier nibble with a channel number.
    function automatic logic [TDC_W-1:0] stamp_id(input logic [TDC_W-1:0] word,
                                                  input logic [ID_W-1:0]  ch);
        logic [TDC_W-1:0] s;
        s = word;
        s[ID_MSB:ID_LSB] = ch;
        return s;
    endfunction

endpackage

// File: rtl/tdc_s3_readout_arbiter_if.sv
// Channel-side and downstream-side signals of the readout arbiter.
// slave = the arbiter, master = the surrounding FIFOs / readout logic.
interface tdc_s3_readout_arbiter_if #(
    parameter int NCH = 4
);
    import tdc_s3_pkg::*;

    localparam int GW = clog2(NCH);

    logic [NCH-1:0]       CH_EN;
    logic [NCH-1:0]       CH_EMPTY;
    logic [NCH*TDC_W-1:0] CH_DATA;
    logic [NCH-1:0]       CH_READ;
    logic                 FIFO_READ;
    logic                 FIFO_EMPTY;
    logic [TDC_W-1:0]     FIFO_DATA;
    logic [TDC_W-1:0]     WORD_CNT;
    logic [GW-1:0]        GRANT;

    modport slave (
        input  CH_EN, CH_EMPTY, CH_DATA, FIFO_READ,
        output CH_READ, FIFO_EMPTY, FIFO_DATA, WORD_CNT, GRANT
    );

    modport master (
        output CH_EN, CH_EMPTY, CH_DATA, FIFO_READ,
        input  CH_READ, FIFO_EMPTY, FIFO_DATA, WORD_CNT, GRANT
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin search: first requester after 'last', wrapping modulo N.
// Purely combinational; 'last' itself is examined only after a full wrap.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] idx
);

    // Explicit modulo wrap so non-power-of-2 N never yields an index >= N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N) sum = sum - N;
        return W'(sum);
    endfunction

    // Walk last+1 .. last+N and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path infers a latch.
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[wrap_add(last, k)]) begin
                found = 1'b1;
                idx   = wrap_add(last, k);
            end
        end
    end

endmodule

// File: rtl/tdc_s3_readout_arbiter.sv
// Merges NCH per-channel FWFT FIFOs into one FWFT stream with round-robin
// grants of at most BURST_LEN words, an optional channel-ID stamp and a
// saturating delivered-word counter.
module tdc_s3_readout_arbiter
    import tdc_s3_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int BURST_LEN = 8,
    parameter bit CH_ID_EN  = 1'b0
) (
    input logic                     BUS_CLK,
    input logic                     RST,
    tdc_s3_readout_arbiter_if.slave bus
);

    localparam int              GW         = clog2(NCH);
    localparam logic [GW-1:0]   GRANT_RST  = GW'(NCH - 1);
    localparam logic [7:0]      BURST_LAST = 8'(BURST_LEN);

    arb_state_t       state, state_nxt;
    logic [GW-1:0]    grant, grant_nxt;
    logic [7:0]       burst_cnt, burst_cnt_nxt;
    logic             out_valid;
    logic [TDC_W-1:0] out_data;
    logic [TDC_W-1:0] word_cnt;

    logic [NCH-1:0]   req;
    logic             found;
    logic [GW-1:0]    pick_idx;
    logic             can_load;
    logic             drain;
    logic             grant_ok;
    logic             pop;
    logic [TDC_W-1:0] sel_data;
    logic [TDC_W-1:0] load_data;

    assign req = bus.CH_EN & ~bus.CH_EMPTY;

    rr_priority_pick #(
        .N (NCH),
        .W (GW)
    ) u_pick (
        .req   (req),
        .last  (grant),
        .found (found),
        .idx   (pick_idx)
    );

    // The output register may take a word when empty or being emptied this cycle.
    assign can_load = !out_valid || bus.FIFO_READ;
    assign drain    = out_valid && bus.FIFO_READ;
    assign grant_ok = req[grant];
    // RST gates the pop so a reset mid-burst never steals a word from the channel.
    assign pop      = (state == ST_GRANT) && can_load && grant_ok && !RST;

    assign sel_data  = bus.CH_DATA[32'(grant)*TDC_W +: TDC_W];
    assign load_data = CH_ID_EN ? stamp_id(sel_data, ID_W'(grant)) : sel_data;

    assign bus.FIFO_EMPTY = !out_valid;
    assign bus.FIFO_DATA  = out_data;
    assign bus.WORD_CNT   = word_cnt;
    assign bus.GRANT      = grant;

    // One-hot pop strobe towards the granted channel.
    always_comb begin
        bus.CH_READ = '0;
        if (pop) bus.CH_READ[grant] = 1'b1;
    end

    // Next-state logic: search in IDLE, count pops and yield in GRANT.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        burst_cnt_nxt = burst_cnt;
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!grant_ok) begin
                    state_nxt = ST_IDLE;
                end else if (pop) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (burst_cnt + 8'd1 == BURST_LAST) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbiter state register; GRANT resets to NCH-1 so channel 0 is searched first.
    always_ff @(posedge BUS_CLK) begin
        // NOTE: clocked blocks use <= so every register samples pre-edge values.
        if (RST) begin
            state     <= ST_IDLE;
            grant     <= GRANT_RST;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Output stage and saturating delivered-word counter.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            word_cnt  <= '0;
        end else begin
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain && word_cnt != '1) word_cnt <= word_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_tdc_s3_readout_arbiter.sv
// Directed bench for tdc_s3_readout_arbiter: NCH=4, BURST_LEN=8, CH_ID_EN=1.
// Channel FIFOs are modelled as simple arrays with read/write pointers.
module tb_tdc_s3_readout_arbiter;
    import tdc_s3_pkg::*;

    localparam int NCH = 4;

    logic BUS_CLK;
    logic RST;

    tdc_s3_readout_arbiter_if #(.NCH(NCH)) bus ();

    tdc_s3_readout_arbiter #(
        .NCH       (NCH),
        .BURST_LEN (8),
        .CH_ID_EN  (1'b1)
    ) dut (
        .BUS_CLK (BUS_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Channel FIFO models: mem/wr_ptr written by the stimulus, rd_ptr by the pop process.
    logic [31:0] mem [NCH][256];
    int          wr_ptr [NCH] = '{default: 0};
    int          rd_ptr [NCH] = '{default: 0};

    // Received-word log, written only by the monitor.
    logic [31:0] rx_data [256];
    int          rx_cyc  [256];
    int          rx_cnt    = 0;
    int          cyc       = 0;
    int          bad_reads = 0;

    always_comb begin
        bus.CH_EMPTY = '0;
        bus.CH_DATA  = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.CH_EMPTY[i]          = (rd_ptr[i] == wr_ptr[i]);
            bus.CH_DATA[i*32 +: 32]  = mem[i][rd_ptr[i] & 255];
        end
    end

    always @(posedge BUS_CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NCH; i++)
            if (bus.CH_READ[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end

    always @(negedge BUS_CLK) begin
        if (!$onehot0(bus.CH_READ) || ((bus.CH_READ & ~(bus.CH_EN & ~bus.CH_EMPTY)) != '0))
            bad_reads = bad_reads + 1;
        if (bus.FIFO_READ && !bus.FIFO_EMPTY && rx_cnt < 256) begin
            rx_data[rx_cnt] = bus.FIFO_DATA;
            rx_cyc[rx_cnt]  = cyc;
            rx_cnt          = rx_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    // Raw channel word: top nibble 0xA so the ID stamp is visible.
    function automatic logic [31:0] wd(input int ch, input int n);
        return {4'hA, 4'(ch), 16'h0000, 8'(n)};
    endfunction

    // Same word after the arbiter stamps the channel into [31:28].
    function automatic logic [31:0] ew(input int ch, input int n);
        return {4'(ch), 4'(ch), 16'h0000, 8'(n)};
    endfunction

    task automatic push(input int ch, input logic [31:0] w);
        mem[ch][wr_ptr[ch] & 255] = w;
        wr_ptr[ch] = wr_ptr[ch] + 1;
    endtask

    // Hold reset, drop any leftover channel contents, leave RST high for preload.
    task automatic do_reset();
        RST           = 1'b1;
        bus.FIFO_READ = 1'b0;
        bus.CH_EN     = '1;
        for (int i = 0; i < NCH; i++) wr_ptr[i] = rd_ptr[i];
        tick(2);
    endtask

    int base;
    int p0;
    int exp_ch;
    int exp_n;
    int exp_gap;

    initial begin
        RST           = 1'b1;
        bus.FIFO_READ = 1'b0;
        bus.CH_EN     = '1;

        // ---- 1: two channels, three words each -----------------------------
        do_reset();
        check("rst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        check("rst_data",  bus.FIFO_DATA, 32'h0);
        check("rst_wcnt",  bus.WORD_CNT, 32'h0);
        check("rst_grant", 32'(bus.GRANT), 32'd3);
        check("rst_read",  32'(bus.CH_READ), 32'd0);
        bus.FIFO_READ = 1'b1;
        for (int n = 0; n < 3; n++) begin
            push(0, wd(0, n));
            push(2, wd(2, n));
        end
        base = rx_cnt;
        RST  = 1'b0;
        tick();
        check("t1_empty_c1", 32'(bus.FIFO_EMPTY), 32'd1);
        check("t1_grant_c1", 32'(bus.GRANT), 32'd0);
        tick();
        check("t1_empty_c2", 32'(bus.FIFO_EMPTY), 32'd0);
        check("t1_data_c2",  bus.FIFO_DATA, ew(0, 0));
        tick(12);
        check("t1_count", 32'(rx_cnt - base), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_word%0d", i), rx_data[base + i], ew(i < 3 ? 0 : 2, i % 3));
        check("t1_wcnt",  bus.WORD_CNT, 32'd6);
        check("t1_grant", 32'(bus.GRANT), 32'd2);
        check("t1_empty_end", 32'(bus.FIFO_EMPTY), 32'd1);

        // ---- 2: two busy channels, bursts of 8 -----------------------------
        do_reset();
        bus.FIFO_READ = 1'b1;
        for (int n = 0; n < 20; n++) begin
            push(0, wd(0, n));
            push(1, wd(1, n));
        end
        base = rx_cnt;
        RST  = 1'b0;
        tick(60);
        check("t2_count", 32'(rx_cnt - base), 32'd40);
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                exp_ch = (i / 8) % 2;
                exp_n  = (i / 16) * 8 + (i % 8);
            end else begin
                exp_ch = (i < 36) ? 0 : 1;
                exp_n  = 16 + (i % 4);
            end
            check($sformatf("t2_word%0d", i), rx_data[base + i], ew(exp_ch, exp_n));
        end
        // Bursts of 8 are separated by one IDLE cycle; a channel that runs dry
        // costs an extra cycle for the grant exit.
        for (int i = 1; i < 40; i++) begin
            exp_gap = (i == 36) ? 3 : ((i % 8) == 0 ? 2 : 1);
            check($sformatf("t2_gap%0d", i), 32'(rx_cyc[base + i] - rx_cyc[base + i - 1]),
                  32'(exp_gap));
        end
        check("t2_wcnt", bus.WORD_CNT, 32'd40);

        // ---- 3: downstream stall ------------------------------------------
        do_reset();
        for (int n = 0; n < 4; n++) push(1, wd(1, n));
        p0  = rd_ptr[1];
        RST = 1'b0;
        tick(3);
        check("t3_empty_early", 32'(bus.FIFO_EMPTY), 32'd0);
        check("t3_data_early",  bus.FIFO_DATA, ew(1, 0));
        tick(7);
        check("t3_pops_stall",  32'(rd_ptr[1] - p0), 32'd1);
        check("t3_empty_late",  32'(bus.FIFO_EMPTY), 32'd0);
        check("t3_data_late",   bus.FIFO_DATA, ew(1, 0));
        check("t3_grant",       32'(bus.GRANT), 32'd1);
        base          = rx_cnt;
        bus.FIFO_READ = 1'b1;
        tick(8);
        check("t3_count", 32'(rx_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_word%0d", i), rx_data[base + i], ew(1, i));
        for (int i = 1; i < 4; i++)
            check($sformatf("t3_gap%0d", i), 32'(rx_cyc[base + i] - rx_cyc[base + i - 1]), 32'd1);
        check("t3_pops_total", 32'(rd_ptr[1] - p0), 32'd4);

        // ---- 4: channel ID stamp and disabled channel ----------------------
        do_reset();
        push(3, 32'h4ABC_D123);
        RST = 1'b0;
        tick(3);
        check("t4_empty", 32'(bus.FIFO_EMPTY), 32'd0);
        check("t4_stamp", bus.FIFO_DATA, 32'h3ABC_D123);
        bus.CH_EN = 4'b0111;
        p0        = rd_ptr[3];
        base      = rx_cnt;
        bus.FIFO_READ = 1'b1;
        tick();
        check("t4_delivered", 32'(rx_cnt - base), 32'd1);
        check("t4_deliv_data", rx_data[base], 32'h3ABC_D123);
        push(3, wd(3, 1));
        push(3, wd(3, 2));
        tick(10);
        check("t4_no_pop_dis", 32'(rd_ptr[3] - p0), 32'd0);
        check("t4_empty_dis",  32'(bus.FIFO_EMPTY), 32'd1);
        check("t4_count_dis",  32'(rx_cnt - base), 32'd1);
        check("t4_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // ---- 5: reset in the middle of a ch2 burst -------------------------
        do_reset();
        bus.FIFO_READ = 1'b1;
        for (int n = 0; n < 6; n++) push(2, wd(2, n));
        RST = 1'b0;
        tick(4);
        check("t5_grant_mid", 32'(bus.GRANT), 32'd2);
        push(1, wd(1, 0));
        push(1, wd(1, 1));
        push(3, wd(3, 0));
        p0  = rd_ptr[2];
        RST = 1'b1;
        #1;
        check("t5_read_in_rst", 32'(bus.CH_READ), 32'd0);
        tick();
        RST = 1'b0;
        check("t5_no_pop_rst", 32'(rd_ptr[2] - p0), 32'd0);
        check("t5_empty",      32'(bus.FIFO_EMPTY), 32'd1);
        check("t5_wcnt",       bus.WORD_CNT, 32'd0);
        check("t5_grant_rst",  32'(bus.GRANT), 32'd3);
        check("t5_state",      32'(dut.state), 32'(ST_IDLE));
        tick();
        check("t5_grant_next", 32'(bus.GRANT), 32'd1);
        tick();
        check("t5_empty_next", 32'(bus.FIFO_EMPTY), 32'd0);
        check("t5_data_next",  bus.FIFO_DATA, ew(1, 0));

        // ---- 6: word counter saturation ------------------------------------
        do_reset();
        bus.FIFO_READ = 1'b1;
        for (int n = 0; n < 3; n++) push(0, wd(0, n));
        base = rx_cnt;
        RST  = 1'b0;
        dut.word_cnt = 32'hFFFF_FFFE;
        tick(3);
        check("t6_wcnt_first", bus.WORD_CNT, 32'hFFFF_FFFF);
        tick(5);
        check("t6_count",      32'(rx_cnt - base), 32'd3);
        check("t6_wcnt_held",  bus.WORD_CNT, 32'hFFFF_FFFF);

        // ---- ignored read while empty, and pop legality over the whole run -
        tick(2);
        check("t7_empty_read", 32'(bus.FIFO_EMPTY), 32'd1);
        check("t7_wcnt_noinc", bus.WORD_CNT, 32'hFFFF_FFFF);
        check("bad_ch_reads",  32'(bad_reads), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdc_s3_readout_arbiter.md
Name: tdc_s3_readout_arbiter

Overview:
- Merges the 32-bit readout FIFOs of NCH tdc_s3_core channels into one FWFT-style readout stream in the BUS_CLK domain.
- Uses round-robin arbitration with a bounded burst per grant.
- Can optionally stamp the channel number into the data-identifier nibble.
- Sits between the per-channel TDC FIFOs and the system readout / SiTCP FIFO.

Parameters:
- NCH, 4, number of TDC channels (2..16)
- BURST_LEN, 8, maximum words popped per grant (1..255)
- CH_ID_EN, 0, 1 = replace FIFO_DATA[31:28] with the channel index (4 bits); 0 = pass data unchanged

Ports:
- BUS_CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- CH_EN  in  NCH  per-channel enable mask, quasi-static
- CH_EMPTY  in  NCH  channel FIFO empty
- CH_DATA  in  NCH*32  channel FWFT data; channel i occupies [32*i+31:32*i]
- CH_READ  out  NCH  channel pop strobe, one-hot or zero
- FIFO_READ  in  1  downstream pop
- FIFO_EMPTY  out  1  downstream empty
- FIFO_DATA  out  32  downstream data
- WORD_CNT  out  32  words delivered downstream, saturating
- GRANT  out  clog2(NCH)  currently or last granted channel (status)

Behaviour:
- Reset values:
  - CH_READ = 0, FIFO_EMPTY = 1, FIFO_DATA = 0, WORD_CNT = 0, GRANT = NCH-1 (so channel 0 is searched first).
  - State = IDLE, burst_cnt = 0.
- Output stage is a single register: out_valid / out_data.
  - FIFO_EMPTY = !out_valid; FIFO_DATA = out_data.
  - can_load = !out_valid | FIFO_READ.
  - Full throughput: 1 word/cycle while FIFO_READ is held high.
- Channel handshake:
  - CH_READ[g] is asserted combinationally in GRANT when can_load & CH_EN[g] & !CH_EMPTY[g].
  - Same cycle: out_data <= CH_DATA[g] (with channel ID stamped if CH_ID_EN), out_valid <= 1.
  - If FIFO_READ & out_valid and no load: out_valid <= 0. out_data holds its last value.
  - Never assert CH_READ on an empty or disabled channel.
- State machine (2 states):
  - IDLE:
    - Search channels GRANT+1, GRANT+2, … modulo NCH for the first with CH_EN & !CH_EMPTY.
    - If found: GRANT <= index, burst_cnt <= 0, go to GRANT. Otherwise stay in IDLE.
    - No pop occurs in IDLE.
  - GRANT:
    - On each pop, burst_cnt++.
    - Go to IDLE after the pop that makes burst_cnt == BURST_LEN.
    - Also go to IDLE in any cycle where CH_EMPTY[g] or !CH_EN[g]; this exit is taken without a pop.
    - Stalls (can_load = 0) keep the grant; burst_cnt is held.
- Latency: CH_EMPTY falls at cycle t (arbiter IDLE) → GRANT at t+1 → CH_READ at t+1 → FIFO_EMPTY low at t+2.
- Fairness: the search always starts at the last grant + 1, so a continuously busy channel yields after BURST_LEN words.
- WORD_CNT increments on FIFO_READ & out_valid and saturates at 0xFFFFFFFF.
- FIFO_READ while FIFO_EMPTY is ignored: no count, no state change.
- Reset mid-burst:
  - Pending out_data is discarded, state returns to IDLE, and no CH_READ is asserted in the reset cycle.
  - The channel FIFOs are not reset by this block.
- CH_EN deasserted mid-grant: the current word in the output stage is still delivered; no further pops from that channel.
- All channels disabled or empty: the block stays in IDLE with FIFO_EMPTY = 1.
- NCH not a power of 2: modulo wrap is explicit; GRANT never exceeds NCH-1.

Decomposition:
- Shared package tdc_s3_pkg holds:
  - TDC word width (32)
  - identifier field position [31:28]
  - a clog2 function for GRANT width
- One natural sub-module: rr_priority_pick (combinational round-robin search; inputs request vector and last index; outputs found flag and index), reusable by other basil arbiters.
- The output register, counters and FSM stay in the top module.

Test Plan:
- Channels 0 and 2 each preload 3 words, FIFO_READ held high, BURST_LEN = 8.
  - Expect order ch0 w0..w2, then ch2 w0..w2.
  - First FIFO_EMPTY = 0 two cycles after the RST release with data present.
  - Expect WORD_CNT = 6.
- Channels 0 and 1 each hold 20 words, BURST_LEN = 8.
  - Expect order ch0 ×8, ch1 ×8, ch0 ×8, ch1 ×8, ch0 ×4, ch1 ×4.
  - Expect one IDLE bubble between bursts.
- FIFO_READ low for 10 cycles with ch1 non-empty.
  - Expect exactly one CH_READ[1] pulse, FIFO_EMPTY = 0, out_data stable.
  - Releasing FIFO_READ resumes at 1 word/cycle.
- CH_ID_EN = 1, ch3 word 0x4ABC_D123.
  - Expect FIFO_DATA = 0x3ABC_D123.
  - Expect CH_EN[3] = 0 to stall ch3 entirely (no CH_READ[3]).
- Assert RST for 1 cycle in the middle of a ch2 burst.
  - Expect FIFO_EMPTY = 1, WORD_CNT = 0, GRANT = NCH-1, state IDLE next cycle.
  - Next grant goes to the lowest non-empty enabled channel.
- Force WORD_CNT to 0xFFFFFFFE and read 3 words.
  - Expect WORD_CNT = 0xFFFFFFFF, held.
